// File: rtl/core_trap_ctrl.sv
// core_trap_ctrl: sequences trap entry and MRET/SRET return.
// Drives the implicit CSR write ports and the privilege-mode update, then issues
// a one-cycle PC redirect. Sequence: IDLE -> DECIDE -> WRITE -> REDIRECT -> IDLE.
// Ports:
//   trap_req_*  trap request (valid/ready) with cause, interrupt flag, pc, tval
//   xret_*      MRET/SRET request (valid/ready); a trap wins a same-cycle tie
//   prv_mode    current privilege mode; csr_*  current CSR values
//   *_in/*_we   CSR and privilege write data/enables, asserted only in WRITE
//   redirect_*  one-cycle redirect strobe and held target; busy = not IDLE
module core_trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req_valid,
  output logic        trap_req_ready,
  input  logic        trap_is_interrupt,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        xret_valid,
  output logic        xret_ready,
  input  logic        xret_is_mret,
  input  logic [1:0]  prv_mode,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_medeleg,
  input  logic [31:0] csr_mideleg,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_stvec,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] csr_sepc,
  output logic [1:0]  prv_mode_in,
  output logic        prv_mode_we,
  output logic [31:0] csr_mstatus_in,
  output logic        csr_mstatus_we,
  output logic [31:0] csr_mepc_in,
  output logic        csr_mepc_we,
  output logic [31:0] csr_mcause_in,
  output logic        csr_mcause_we,
  output logic [31:0] csr_sepc_in,
  output logic        csr_sepc_we,
  output logic [31:0] csr_scause_in,
  output logic        csr_scause_we,
  output logic [31:0] csr_stval_in,
  output logic        csr_stval_we,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [1:0] PRV_M = 2'd3;
  localparam logic [1:0] PRV_S = 2'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_WRITE, ST_REDIRECT} state_t;
  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q;
  logic [4:0]  cause_q;
  logic        intr_q;
  logic [31:0] pc_q;
  logic [31:0] tval_q;
  logic [1:0]  prv_q;
  logic        deleg_q;
  logic [31:0] rpc_q;

  logic        trap_acc, xret_acc;
  logic        deleg_d;
  logic [31:0] ms;
  logic [31:0] tvec;
  logic [31:0] base;
  logic [31:0] target;
  logic [1:0]  mpp;

  // State register and per-request context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= K_TRAP;
      cause_q <= 5'd0;
      intr_q  <= 1'b0;
      pc_q    <= 32'd0;
      tval_q  <= 32'd0;
      prv_q   <= 2'd0;
      deleg_q <= 1'b0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (trap_acc) begin
        kind_q  <= K_TRAP;
        cause_q <= trap_cause;
        intr_q  <= trap_is_interrupt;
        pc_q    <= trap_pc;
        tval_q  <= trap_tval;
        prv_q   <= prv_mode;
      end else if (xret_acc) begin
        kind_q  <= xret_is_mret ? K_MRET : K_SRET;
        prv_q   <= prv_mode;
      end
      if (state_q == ST_DECIDE) deleg_q <= deleg_d;
      // Keep the target visible after the strobe drops
      if (state_q == ST_REDIRECT) rpc_q <= target;
    end
  end

  // Next-state, handshake, CSR write and redirect outputs
  always_comb begin
    state_d        = state_q;
    trap_req_ready = 1'b0;
    xret_ready     = 1'b0;
    trap_acc       = 1'b0;
    xret_acc       = 1'b0;
    deleg_d        = 1'b0;
    ms             = csr_mstatus;
    mpp            = csr_mstatus[12:11];
    tvec           = deleg_q ? csr_stvec : csr_mtvec;
    base           = tvec & ~32'd3;
    target         = base;
    prv_mode_in    = 2'd0;
    prv_mode_we    = 1'b0;
    csr_mstatus_in = 32'd0;
    csr_mstatus_we = 1'b0;
    csr_mepc_in    = 32'd0;
    csr_mepc_we    = 1'b0;
    csr_mcause_in  = 32'd0;
    csr_mcause_we  = 1'b0;
    csr_sepc_in    = 32'd0;
    csr_sepc_we    = 1'b0;
    csr_scause_in  = 32'd0;
    csr_scause_we  = 1'b0;
    csr_stval_in   = 32'd0;
    csr_stval_we   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = rpc_q;
    busy           = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        trap_req_ready = 1'b1;
        xret_ready     = !trap_req_valid;
        trap_acc       = trap_req_valid;
        xret_acc       = xret_valid && !trap_req_valid;
        if (trap_acc || xret_acc) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        // Delegation uses the privilege captured at accept, never the live input
        if (kind_q == K_TRAP)
          deleg_d = (prv_q != PRV_M) &&
                    (intr_q ? csr_mideleg[cause_q] : csr_medeleg[cause_q]);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        prv_mode_we    = 1'b1;
        csr_mstatus_we = 1'b1;
        case (kind_q)
          K_TRAP: begin
            if (deleg_q) begin
              ms[5]         = csr_mstatus[1];
              ms[1]         = 1'b0;
              ms[8]         = prv_q[0];
              csr_sepc_in   = {pc_q[31:2], 2'b00};
              csr_sepc_we   = 1'b1;
              csr_scause_in = {intr_q, 26'd0, cause_q};
              csr_scause_we = 1'b1;
              csr_stval_in  = tval_q;
              csr_stval_we  = 1'b1;
              prv_mode_in   = PRV_S;
            end else begin
              ms[7]         = csr_mstatus[3];
              ms[3]         = 1'b0;
              ms[12:11]     = prv_q;
              csr_mepc_in   = {pc_q[31:2], 2'b00};
              csr_mepc_we   = 1'b1;
              csr_mcause_in = {intr_q, 26'd0, cause_q};
              csr_mcause_we = 1'b1;
              prv_mode_in   = PRV_M;
            end
          end
          K_MRET: begin
            ms[3]     = csr_mstatus[7];
            ms[7]     = 1'b1;
            ms[12:11] = 2'b00;
            if (mpp != PRV_M) ms[17] = 1'b0;
            prv_mode_in = mpp;
          end
          default: begin
            ms[1]       = csr_mstatus[5];
            ms[5]       = 1'b1;
            ms[8]       = 1'b0;
            ms[17]      = 1'b0;
            prv_mode_in = {1'b0, csr_mstatus[8]};
          end
        endcase
        csr_mstatus_in = ms;
        state_d        = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        case (kind_q)
          K_MRET:  target = csr_mepc;
          K_SRET:  target = csr_sepc;
          default: begin
            // Vectored mode only offsets interrupts
            if (tvec[1:0] == 2'b01 && intr_q)
              target = base + {25'd0, cause_q, 2'b00};
          end
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = target;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
